// File: rtl/eth_tx_buf_stream.sv
// eth_tx_buf_stream: 16 KiB host-writable transmit buffer that streams a frame
// out as 16-bit AXI-Stream beats. The host port reads/writes 64-bit words with
// byte enables; the stream side reads words, prefetches the next one and slices
// each word into four beats, lowest lane first.
//
// Build option: define TX_BUF_PAD_EN to pad short frames to 60 bytes. Pad bytes
// are sent as 0x00 and words lying entirely in the pad region are never read.
//
// Stream handshake: a beat transfers on a rising edge where tx_tvalid_o and
// tx_tready_i are both high. Once tx_tvalid_o is raised, tdata/tkeep/tlast hold
// their values and tvalid stays high until that beat has transferred.
module eth_tx_buf_stream #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [7:0]        host_we_i,
    input  logic [63:0]       host_wdata_i,
    output logic [63:0]       host_rdata_o,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       tx_tdata_o,
    output logic [1:0]        tx_tkeep_o,
    output logic              tx_tvalid_o,
    input  logic              tx_tready_i,
    output logic              tx_tlast_o
);

    localparam logic [14:0] MAX_LEN = 15'd16384;
`ifdef TX_BUF_PAD_EN
    localparam logic [14:0] PAD_LEN = 15'd60;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Buffer storage and the stream-side prefetch word.
    logic [63:0]       mem [2**ADDR_W];
    logic [63:0]       pf_word;
    logic [63:0]       word_buf;
    logic [ADDR_W-1:0] rd_addr;

    // Frame bookkeeping: effective length, length of real data, next beat position.
    logic [14:0] eff_len;
    logic [14:0] data_len;
    logic [14:0] byte_pos;
    logic [1:0]  lane;

    // Control strobes from the FSM.
    logic accept;
    logic rd_en;
    logic load_beat;
    logic from_ram;
    logic finish;

    // Length handling for a newly accepted start.
    logic [14:0] len_sat;
    logic [14:0] len_eff_new;

    // Beat construction.
    logic [63:0] src_word;
    logic [15:0] src_lane;
    logic [15:0] pos1;
    logic [15:0] pos2;
    logic        keep_lo;
    logic        keep_hi;
    logic        data_lo;
    logic        data_hi;
    logic        beat_last;
    logic [15:0] beat_data;
    logic        need_word;

    // Saturate the requested length and apply the minimum-frame pad if built in.
    always_comb begin
        if (32'(len_i) > 32'(MAX_LEN)) begin
            len_sat = MAX_LEN;
        end else begin
            len_sat = 15'(len_i);
        end
`ifdef TX_BUF_PAD_EN
        len_eff_new = (len_sat < PAD_LEN) ? PAD_LEN : len_sat;
`else
        len_eff_new = len_sat;
`endif
    end

`ifdef TX_BUF_PAD_EN
    // Real payload length; bytes at or beyond it go out as zero pad.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_len <= '0;
        end else if (accept) begin
            data_len <= len_sat;
        end
    end
`else
    assign data_len = eff_len;
`endif

    // The next unread word holds at least one payload byte.
    assign need_word = (32'({rd_addr, 3'b000}) < 32'(data_len));

    // Slice the selected lane and qualify each byte against the frame lengths.
    always_comb begin
        src_word = from_ram ? pf_word : word_buf;
        case (lane)
            2'd0:    src_lane = src_word[15:0];
            2'd1:    src_lane = src_word[31:16];
            2'd2:    src_lane = src_word[47:32];
            default: src_lane = src_word[63:48];
        endcase
        pos1      = {1'b0, byte_pos} + 16'd1;
        pos2      = {1'b0, byte_pos} + 16'd2;
        keep_lo   = (byte_pos < eff_len);
        keep_hi   = (pos1 < {1'b0, eff_len});
        data_lo   = (byte_pos < data_len);
        data_hi   = (pos1 < {1'b0, data_len});
        beat_last = (pos2 >= {1'b0, eff_len});
        beat_data = {(data_hi ? src_lane[15:8] : 8'h00),
                     (data_lo ? src_lane[7:0]  : 8'h00)};
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state and datapath strobes.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rd_en      = 1'b0;
        load_beat  = 1'b0;
        from_ram   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    rd_en      = (len_sat != 15'd0);
                    next_state = (len_eff_new == 15'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                load_beat  = 1'b1;
                from_ram   = 1'b1;
                rd_en      = need_word;
                next_state = STREAM;
            end
            STREAM: begin
                if (tx_tvalid_o && tx_tready_i) begin
                    if (tx_tlast_o) begin
                        finish     = 1'b1;
                        next_state = DONE;
                    end else begin
                        load_beat = 1'b1;
                        if (lane == 2'd0) begin
                            from_ram = 1'b1;
                            rd_en    = need_word;
                        end
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    // Stream datapath: frame counters, word pointer and the registered output beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            eff_len     <= '0;
            byte_pos    <= '0;
            lane        <= '0;
            rd_addr     <= '0;
            word_buf    <= '0;
            tx_tvalid_o <= 1'b0;
            tx_tdata_o  <= '0;
            tx_tkeep_o  <= '0;
            tx_tlast_o  <= 1'b0;
        end else begin
            if (accept) begin
                eff_len  <= len_eff_new;
                byte_pos <= '0;
                lane     <= '0;
            end
            if (rd_en) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
            if (state == DONE) begin
                rd_addr <= '0;
            end
            if (load_beat) begin
                tx_tvalid_o <= 1'b1;
                tx_tdata_o  <= beat_data;
                tx_tkeep_o  <= {keep_hi, keep_lo};
                tx_tlast_o  <= beat_last;
                byte_pos    <= byte_pos + 15'd2;
                lane        <= lane + 2'd1;
                if (from_ram) begin
                    word_buf <= pf_word;
                end
            end
            if (finish) begin
                tx_tvalid_o <= 1'b0;
                tx_tdata_o  <= '0;
                tx_tkeep_o  <= '0;
                tx_tlast_o  <= 1'b0;
            end
        end
    end

    // Host port write with per-byte enables; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < 8; n++) begin
            if (host_we_i[n]) begin
                mem[host_addr_i][8*n +: 8] <= host_wdata_i[8*n +: 8];
            end
        end
    end

    // Host port read, one cycle latency, returns pre-write data on a collision.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            host_rdata_o <= '0;
        end else begin
            host_rdata_o <= mem[host_addr_i];
        end
    end

    // Stream port read into the prefetch word; only issued when a word is needed.
    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            pf_word <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_eth_tx_buf_stream.sv
// Testbench for eth_tx_buf_stream: randomised frames checked against a byte-level
// model of the buffer; expected beats are queued at start and popped by a monitor.
module tb_eth_tx_buf_stream;

    localparam int ADDR_W = 11;
    localparam int LEN_W  = 15;
    localparam int WORDS  = 2**ADDR_W;

    // ---------------- clock / reset / signals ----------------
    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_we;
    logic [63:0]       host_wdata;
    logic [63:0]       host_rdata;
    logic              start;
    logic [LEN_W-1:0]  len_in;
    logic              busy;
    logic              done;
    logic [15:0]       tdata;
    logic [1:0]        tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    eth_tx_buf_stream #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .host_addr_i  (host_addr),
        .host_we_i    (host_we),
        .host_wdata_i (host_wdata),
        .host_rdata_o (host_rdata),
        .start_i      (start),
        .len_i        (len_in),
        .busy_o       (busy),
        .done_o       (done),
        .tx_tdata_o   (tdata),
        .tx_tkeep_o   (tkeep),
        .tx_tvalid_o  (tvalid),
        .tx_tready_i  (tready),
        .tx_tlast_o   (tlast)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          rdy_mode = 0;
    logic [63:0] shadow [WORDS];
    logic [18:0] exp_q[$];
    logic [18:0] mon_exp;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [18:0] prev_beat = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input int b);
        logic [63:0] w;
        w = shadow[b / 8];
        return w[8*(b % 8) +: 8];
    endfunction

    // Reference model: frame as a byte string, two bytes per beat.
    task automatic push_frame(input int len, output int nbeats);
        int lsat;
        int eff;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [1:0] keep;
        logic       last;
        lsat = (len > 16384) ? 16384 : len;
        eff  = lsat;
`ifdef TX_BUF_PAD_EN
        if (eff < 60) eff = 60;
`endif
        nbeats = (eff + 1) / 2;
        for (int i = 0; i < nbeats; i++) begin
            lo   = (2*i     < lsat) ? mem_byte(2*i)     : 8'h00;
            hi   = (2*i + 1 < lsat) ? mem_byte(2*i + 1) : 8'h00;
            keep = {(2*i + 1 < eff), 1'b1};
            last = (i == nbeats - 1);
            exp_q.push_back({last, keep, hi, lo});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic host_write(input int addr, input logic [63:0] data, input logic [7:0] we);
        host_addr  = ADDR_W'(addr);
        host_wdata = data;
        host_we    = we;
        @(posedge clk);
        #1;
        host_we = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (we[n]) shadow[addr][8*n +: 8] = data[8*n +: 8];
        end
    endtask

    task automatic host_read_check(input int addr);
        host_addr = ADDR_W'(addr);
        @(posedge clk);
        #1;
        check("host_rdata", host_rdata, shadow[addr]);
    endtask

    task automatic run_frame(input int len, input int mode, input bit extra_start);
        int nb;
        int first;
        int done_k;
        bit got_done;
        rdy_mode = mode;
        push_frame(len, nb);
        start  = 1'b1;
        len_in = LEN_W'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (nb == 0) begin
            @(negedge clk);
            check("len0_done_cycle", {busy, done, tvalid}, 3'b110);
            @(negedge clk);
            check("len0_back_idle", {busy, done, tvalid}, 3'b000);
            @(posedge clk);
            #1;
            return;
        end
        first    = -1;
        done_k   = -1;
        got_done = 1'b0;
        for (int k = 0; k < 20000 && !got_done; k++) begin
            @(negedge clk);
            if (tvalid && first < 0) first = k;
            if (extra_start && k == 3) begin
                start  = 1'b1;
                len_in = LEN_W'(4);
            end
            if (extra_start && k == 4) start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                done_k   = k;
            end
        end
        start = 1'b0;
        check("frame_done_seen", got_done, 1'b1);
        check("tvalid_within_3", (first >= 0 && first <= 2), 1'b1);
        if (mode == 0) check("no_bubble_span", done_k - first, nb);
        check("exp_drained", exp_q.size(), 0);
        check("busy_in_done", busy, 1'b1);
        @(negedge clk);
        check("idle_after_done", {busy, done, tvalid}, 3'b000);
        if (extra_start) begin
            repeat (5) @(negedge clk);
            check("ignored_start_quiet", {busy, tvalid}, 2'b00);
        end
        @(posedge clk);
        #1;
    endtask

    // tready pattern: 0 = always ready, 1 = toggle, 2 = random.
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tready = 1'b1;
                1:       tready = ~tready;
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_valid && !prev_ready) begin
                check("stall_hold", {tvalid, tlast, tkeep, tdata}, {1'b1, prev_beat});
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h expected none", {tlast, tkeep, tdata});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat", {tlast, tkeep, tdata}, mon_exp);
                end
            end
            prev_valid = tvalid;
            prev_ready = tready;
            prev_beat  = {tlast, tkeep, tdata};
        end
    end

    // ---------------- main sequence ----------------
    int nb_abort;
    int dc;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        len_in     = '0;
        host_we    = 8'h00;
        host_addr  = '0;
        host_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {busy, done, tvalid, tlast}, 4'b0000);
        check("rst_tdata", tdata, 16'h0000);
        check("rst_tkeep", tkeep, 2'b00);
        check("rst_host_rdata", host_rdata, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int w = 0; w < WORDS; w++) host_write(w, {$urandom, $urandom}, 8'hFF);
        host_write(0, 64'h0807060504030201, 8'hFF);
        host_write(1, 64'h100F0E0D0C0B0A09, 8'hFF);
        host_read_check(0);
        host_read_check(1);
        host_write(2, {$urandom, $urandom}, 8'h5A);
        host_read_check(2);

        run_frame(16, 0, 1'b0);
        run_frame(7, 0, 1'b0);
        run_frame(16, 1, 1'b0);
        run_frame(0, 0, 1'b0);
        run_frame(16, 0, 1'b1);
        run_frame(10, 0, 1'b0);
        run_frame(1, 2, 1'b0);

        // Abort a frame with reset while the third beat is presented.
        rdy_mode = 0;
        push_frame(16, nb_abort);
        start  = 1'b1;
        len_in = LEN_W'(16);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        dc = done_cnt;
        @(negedge clk);
        check("abort_cleared", {busy, done, tvalid, tlast}, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_after_abort", done_cnt - dc, 0);
        @(posedge clk);
        #1;
        run_frame(16, 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            for (int j = 0; j < 3; j++) begin
                host_write($urandom_range(0, 79), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
            end
            run_frame($urandom_range(1, 600), $urandom_range(0, 2), 1'b0);
        end
        run_frame(20000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
